// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clock with a valid strobe and frame marker.
//
//   state | meaning
//   IDLE  | no word held, ready for a new word
//   SHIFT | word in transmission, cnt_q tracks the bit on sd (0..WIDTH-1)
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sd,
    output logic             sd_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sd_q, sd_d;
    logic             sd_valid_q, sd_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             accept;

    // The shift register keeps the next bit to send at its output end.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = (state_q == IDLE) || (cnt_q == LAST);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        sd_d          = 1'b0;
        sd_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = SHIFT;
                    cnt_d         = '0;
                    sd_d          = head(load_data);
                    shreg_d       = advance(load_data);
                    sd_valid_d    = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    // A word offered on the last bit chains into the next frame with no gap.
                    if (accept) begin
                        cnt_d         = '0;
                        sd_d          = head(load_data);
                        shreg_d       = advance(load_data);
                        sd_valid_d    = 1'b1;
                        frame_start_d = 1'b1;
                        busy_d        = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    sd_d       = head(shreg_q);
                    shreg_d    = advance(shreg_q);
                    sd_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sd_q          <= 1'b0;
            sd_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            sd_q          <= sd_d;
            sd_valid_q    <= sd_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign sd          = sd_q;
    assign sd_valid    = sd_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: table of per-cycle vectors for the
// LSB-first 8-bit instance plus hand sequences for reset and MSB-first 4-bit.
`timescale 1ns/1ps
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv8 = 1'b0;
    logic [7:0] ld8 = '0;
    logic       rdy8, sd8, v8, fs8, busy8;
    logic       lv4 = 1'b0;
    logic [3:0] ld4 = '0;
    logic       rdy4, sd4, v4, fs4, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8),
        .load_ready(rdy8), .sd(sd8), .sd_valid(v8), .frame_start(fs8), .busy(busy8)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
        .load_ready(rdy4), .sd(sd4), .sd_valid(v4), .frame_start(fs4), .busy(busy4)
    );

    // exp packs {sd, sd_valid, frame_start, busy, load_ready} after the edge
    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic lv, input logic [7:0] ld,
                                input logic s, input logic v, input logic f,
                                input logic b, input logic r);
        vec_t t;
        t.lv  = lv;
        t.ld  = ld;
        t.exp = {s, v, f, b, r};
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got {sd,v,fs,busy,rdy}=%b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Rows for one frame of an 8-bit LSB-first word with no follow-on load.
    function automatic void add_frame(input logic [7:0] w);
        add(1'b1, w, w[0], 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++)
            add(1'b0, 8'h00, w[k], 1'b1, 1'b0, 1'b1, (k == 7));
    endfunction

    initial begin
        logic [7:0] a5, c3c, xff;
        a5  = 8'hA5;
        c3c = 8'h3C;
        xff = 8'hFF;

        // single word 0xA5, then idle
        add_frame(a5);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back 0xA5 then 0x3C, load_valid held high throughout
        add(1'b1, a5, a5[0], 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++)
            add(1'b1, c3c, a5[k], 1'b1, 1'b0, 1'b1, (k == 7));
        add(1'b1, c3c, c3c[0], 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++)
            add(1'b0, 8'h00, c3c[k], 1'b1, 1'b0, 1'b1, (k == 7));
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 0xFF with a one-cycle load of 0x00 during bit 3 that must be ignored
        add(1'b1, xff, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++)
            add((k == 4), 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, (k == 7));
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("reset8_noclk", {sd8, v8, fs8, busy8, rdy8}, 5'b00001);
        check("reset4_noclk", {sd4, v4, fs4, busy4, rdy4}, 5'b00001);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset8_held", {sd8, v8, fs8, busy8, rdy8}, 5'b00001);

        // table-driven section
        foreach (vecs[i]) begin
            lv8 = vecs[i].lv;
            ld8 = vecs[i].ld;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i), {sd8, v8, fs8, busy8, rdy8}, vecs[i].exp);
        end
        lv8 = 1'b0;
        ld8 = 8'h00;

        // reset during bit 4 of 0xA5
        lv8 = 1'b1;
        ld8 = 8'hA5;
        @(posedge clk);
        #1;
        lv8 = 1'b0;
        ld8 = 8'h00;
        check("mid_start", {sd8, v8, fs8, busy8, rdy8}, 5'b11110);
        repeat (4) @(posedge clk);
        #1;
        check("mid_bit4", {sd8, v8, fs8, busy8, rdy8}, 5'b01010);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_rst", {sd8, v8, fs8, busy8, rdy8}, 5'b00001);
        lv8 = 1'b1;
        ld8 = 8'h01;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lv8 = 1'b0;
        ld8 = 8'h00;
        check("post_rst_bit0", {sd8, v8, fs8, busy8, rdy8}, 5'b11110);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_bit%0d", k), {sd8, v8, fs8, busy8, rdy8},
                  {1'b0, 1'b1, 1'b0, 1'b1, (k == 7)});
        end
        @(posedge clk);
        #1;
        check("post_rst_idle", {sd8, v8, fs8, busy8, rdy8}, 5'b00001);

        // MSB-first, WIDTH=4: 0x8 -> 1,0,0,0
        lv4 = 1'b1;
        ld4 = 4'h8;
        @(posedge clk);
        #1;
        lv4 = 1'b0;
        ld4 = 4'h0;
        check("msb4_bit0", {sd4, v4, fs4, busy4, rdy4}, 5'b11110);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("msb4_bit%0d", k), {sd4, v4, fs4, busy4, rdy4},
                  {1'b0, 1'b1, 1'b0, 1'b1, (k == 3)});
        end
        @(posedge clk);
        #1;
        check("msb4_idle", {sd4, v4, fs4, busy4, rdy4}, 5'b00001);

        // MSB-first 0x6 -> 0,1,1,0 to exercise interior bits
        lv4 = 1'b1;
        ld4 = 4'h6;
        @(posedge clk);
        #1;
        lv4 = 1'b0;
        ld4 = 4'h0;
        check("msb4b_bit0", {sd4, v4, fs4, busy4, rdy4}, 5'b01110);
        @(posedge clk);
        #1;
        check("msb4b_bit1", {sd4, v4, fs4, busy4, rdy4}, 5'b11010);
        @(posedge clk);
        #1;
        check("msb4b_bit2", {sd4, v4, fs4, busy4, rdy4}, 5'b11010);
        @(posedge clk);
        #1;
        check("msb4b_bit3", {sd4, v4, fs4, busy4, rdy4}, 5'b01011);
        @(posedge clk);
        #1;
        check("msb4b_idle", {sd4, v4, fs4, busy4, rdy4}, 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter built from async-reset D flip-flops.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, with an accompanying valid strobe and a frame-start marker.
- Acts as the transmitting end of the single-bit serial links used in the flip-flop and shift-register blocks.

Parameters:
- WIDTH, 8, word length in bits; legal range 2 or more.
- MSB_FIRST, 0, 0 = bit 0 is sent first; 1 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_data  input  WIDTH  parallel word to transmit.
- load_ready  output  1  block accepts a word on this cycle's rising edge.
- sd  output  1  serial data bit.
- sd_valid  output  1  sd carries a valid bit.
- frame_start  output  1  high with the first bit of each word.
- busy  output  1  a frame is in progress.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Reset is asynchronous and active-high on rst; it takes effect immediately, without waiting for a clk edge.
- Reset values:
  - State is IDLE.
  - Shift register and bit counter are 0.
  - sd, sd_valid, frame_start and busy are 0.
  - load_ready is 1.
- States:
  - IDLE: no word held; load_ready = 1.
  - SHIFT: word in transmission; bit counter runs 0..WIDTH-1.
- Transfer and latency:
  - A transfer occurs when load_valid && load_ready are both high at a rising clk edge.
  - On that edge the word is captured and the block goes to SHIFT with count = 0.
  - The first bit appears on sd one cycle after the accept edge.
  - sd_valid stays high for exactly WIDTH consecutive cycles.
  - frame_start is high only during the count == 0 cycle.
- Bit order:
  - MSB_FIRST = 0: sd = load_data[count].
  - MSB_FIRST = 1: sd = load_data[WIDTH-1-count].
  - Implementation choice: a shift register or an indexed mux.
- Registered outputs:
  - sd, sd_valid, frame_start and busy are registered, with no combinational path from the inputs.
  - load_ready is decoded combinationally from registered state only. It never depends on load_valid or load_data.
- Counting and transitions:
  - Bit counter width is $clog2(WIDTH) and is unsigned.
  - The counter increments each cycle in SHIFT.
  - At the last bit (count == WIDTH-1):
    - If a new transfer occurs on that edge, stay in SHIFT, reload the word, reset count to 0 and assert frame_start next cycle. Result: back-to-back frames with zero gap cycles.
    - Otherwise go to IDLE; sd_valid and busy drop to 0 and sd returns to 0.
- load_ready:
  - 1 in IDLE.
  - 1 in SHIFT only when count == WIDTH-1.
  - 0 otherwise.
- busy:
  - High on every cycle where sd_valid is high.
  - Low in IDLE.
- load_valid while load_ready is 0:
  - Ignored; no capture and no state change.
  - The upstream block must hold load_valid and load_data until accepted.
- Changes to load_data after acceptance do not affect the frame in flight.
- Reset mid-frame:
  - The frame is aborted and all outputs go to their reset values immediately.
  - No partial frame resumes after reset is released.
  - The first edge after release may accept a new word.
- load_valid held high continuously:
  - Words stream back-to-back with no gaps.
  - One word is accepted every WIDTH cycles.

Test Plan:
- Reset values: assert rst asynchronously between clk edges, before any clock -> sd = 0, sd_valid = 0, frame_start = 0, busy = 0, load_ready = 1, all immediately.
- Single word, WIDTH = 8, MSB_FIRST = 0: load 0xA5 ->
  - on the 8 cycles after the accept edge, sd = 1,0,1,0,0,1,0,1;
  - sd_valid is high for exactly those 8 cycles;
  - frame_start is high only on the first;
  - load_ready is high on the 8th cycle, then the block returns to IDLE.
- Back-to-back: present 0xA5 and then 0x3C with load_valid held high ->
  - 16 contiguous valid bits, 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0;
  - frame_start is high on cycles 1 and 9;
  - no gap cycle between frames.
- Ignored load: during bit 3 of 0xFF, assert load_valid with 0x00 for one cycle only -> remaining bits are still 1, and no second frame follows.
- Reset mid-frame: start 0xA5, assert rst during bit 4 ->
  - sd_valid and busy drop to 0 without waiting for clk;
  - after release, load 0x01 and observe a clean 8-bit frame 1,0,0,0,0,0,0,0.
- MSB_FIRST = 1, WIDTH = 4: load 0x8 -> sd = 1,0,0,0 with frame_start on the first bit.
